mult_acc: RTL and testbench

- 33-bit accumulator/shift register for the datapath of the sequential shift-and-add multiplier.
- Under control-unit strobes it can:
  - parallel-load an operand;
  - add an operand into its contents;
  - logically shift right by one bit;
  - hold its value.
- Its contents are always visible on the output bus.

---
 rtl/mult_acc.sv | 42 ++++
 tb/tb_mult_acc.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mult_acc.sv
// mult_acc: accumulator / shift register for a shift-and-add multiplier.
// Loads, adds into, or shifts right its contents under control strobes.
module mult_acc #(
  parameter int WIDTH = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Sh,
  input  logic             Ad,
  input  logic [WIDTH-1:0] Entradas,
  output logic [WIDTH-1:0] Saidas
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Next value: load beats add, add beats shift, else hold.
  // The add wraps; its carry out of the MSB is dropped.
  always_comb begin
    acc_d = acc_q;
    if (Load) begin
      acc_d = Entradas;
    end else if (Ad) begin
      acc_d = acc_q + Entradas;
    end else if (Sh) begin
      acc_d = {1'b0, acc_q[WIDTH-1:1]};
    end
  end

  // Accumulator register; Reset overrides every strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Saidas = acc_q;

endmodule

// File: tb/tb_mult_acc.sv
// tb_mult_acc: scoreboard bench for mult_acc.
// Directed cases plus random strobes against an arithmetic model.
module tb_mult_acc;

  localparam int W = 33;

  typedef struct {
    logic [W-1:0] exp;
    string        tag;
  } exp_t;

  logic         Clk;
  logic         Reset;
  logic         Load;
  logic         Sh;
  logic         Ad;
  logic [W-1:0] Entradas;
  logic [W-1:0] Saidas;

  exp_t sb[$];
  int   errors;
  int   checks;

  longint unsigned model;
  longint unsigned modulus;

  mult_acc #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (Load),
    .Sh       (Sh),
    .Ad       (Ad),
    .Entradas (Entradas),
    .Saidas   (Saidas)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of strobes and queue the value expected after it.
  task automatic step(input bit rst, input bit ld,
                      input bit ad, input bit sh,
                      input longint unsigned e,
                      input string tag);
    exp_t it;
    @(negedge Clk);
    Reset    = rst;
    Load     = ld;
    Ad       = ad;
    Sh       = sh;
    Entradas = e[W-1:0];
    if (rst)
      model = 0;
    else if (ld)
      model = e % modulus;
    else if (ad)
      model = (model + (e % modulus)) % modulus;
    else if (sh)
      model = model / 2;
    it.exp = model[W-1:0];
    it.tag = tag;
    sb.push_back(it);
  endtask

  // Monitor: the register is visible every cycle, so compare each edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (Saidas !== it.exp) begin
          errors++;
          $display("FAIL %s: Saidas=0x%0h expected=0x%0h",
                   it.tag, Saidas, it.exp);
        end
      end
    end
  end

  initial begin
    longint unsigned r;
    bit rs, ld, ad, sh;
    errors  = 0;
    checks  = 0;
    model   = 0;
    modulus = 64'd1 << W;
    Reset = 1'b0; Load = 1'b0; Sh = 1'b0; Ad = 1'b0;
    Entradas = '0;

    step(1, 1, 0, 0, 7, "reset_over_load");
    step(0, 1, 0, 0, 7, "load7");
    step(0, 0, 0, 1, 0, "shift7");
    step(0, 0, 1, 0, 496, "add496");
    step(0, 0, 0, 0, 123, "hold499");

    step(0, 1, 0, 0, 15, "load15");
    step(0, 0, 0, 0, 9, "idle15");
    step(0, 0, 0, 1, 0, "shift15");
    step(0, 0, 0, 0, 0, "idle7");
    step(0, 0, 1, 0, 496, "add503");
    step(0, 0, 0, 0, 0, "idle503");

    step(0, 1, 0, 0, 64'h1_FFFF_FFFF, "load_max");
    step(0, 0, 1, 0, 1, "add_wrap");
    step(0, 1, 0, 0, 64'h1_0000_0001, "load_msb_lsb");
    step(0, 0, 0, 1, 0, "shift_msb");

    step(0, 1, 1, 1, 5, "load_wins");
    step(0, 0, 1, 1, 2, "add_wins");

    step(0, 1, 0, 0, 64'h1F0, "load1f0");
    step(0, 0, 0, 1, 0, "sh_a");
    step(0, 0, 0, 1, 0, "sh_b");
    step(1, 0, 0, 1, 0, "reset_mid_shift");
    step(0, 0, 0, 1, 0, "sh_after_rst");
    step(0, 0, 0, 1, 0, "sh_after_rst2");

    for (int i = 0; i < 400; i++) begin
      r  = {32'($urandom), 32'($urandom)};
      rs = ($urandom_range(0, 31) == 0);
      ld = ($urandom_range(0, 4) == 0);
      ad = ($urandom_range(0, 2) == 0);
      sh = ($urandom_range(0, 1) == 0);
      step(rs, ld, ad, sh, r, "random");
    end

    @(negedge Clk);
    Reset = 1'b0; Load = 1'b0; Sh = 1'b0; Ad = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(negedge Clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
